// File: rtl/fir_out_formatter.sv
// FIR output formatter: round, saturate, optionally decimate and queue samples in a FWFT FIFO.
// Optional saturation counter port o_sat_cnt is enabled by defining FIR_FMT_SAT_CNT_EN.
module fir_out_formatter #(
    parameter int IN_WIDTH   = 33,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 1,
    parameter int SKIP       = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic                 i_data_valid,
    input  logic                 i_clr,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_overrun,
`ifdef FIR_FMT_SAT_CNT_EN
    output logic [15:0]          o_sat_cnt,
`endif
    output logic                 o_sat
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic signed [IN_WIDTH:0] RND  = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT-1);
    localparam logic signed [IN_WIDTH:0] MAXV = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] MINV = {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [IN_WIDTH:0] ext_s, sum_s, shr_s;
    logic [OUT_WIDTH-1:0]     fmt_s;
    logic                     clamp_s;
    logic                     skip_done_s, keep_s, sat_set_s;
    logic                     pop_s, full_s, push_s, drop_s;
    logic [AW:0]              cnt_nxt_s;
    logic [OUT_WIDTH-1:0]     head_nxt_s;

    logic [7:0]               skip_r;
    logic [3:0]               phase_r;
    logic                     stage_v_r;
    logic [OUT_WIDTH-1:0]     stage_d_r;
    logic [OUT_WIDTH-1:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]            rd_ptr_r, wr_ptr_r;
    logic [AW:0]              cnt_r;
    logic                     valid_r;
    logic [OUT_WIDTH-1:0]     head_r;
    logic                     overrun_r, sat_r;

    // Round half toward +inf, arithmetic shift, then clamp to the output range.
    always_comb begin
        ext_s = {i_data[IN_WIDTH-1], i_data};
        sum_s = ext_s + RND;
        shr_s = sum_s >>> SHIFT;
        if (shr_s > MAXV) begin
            fmt_s   = MAXV[OUT_WIDTH-1:0];
            clamp_s = 1'b1;
        end else if (shr_s < MINV) begin
            fmt_s   = MINV[OUT_WIDTH-1:0];
            clamp_s = 1'b1;
        end else begin
            fmt_s   = shr_s[OUT_WIDTH-1:0];
            clamp_s = 1'b0;
        end
    end

    // Keep decision and FIFO occupancy / next-head control.
    always_comb begin
        skip_done_s = (skip_r == 8'(SKIP));
        keep_s      = i_data_valid && skip_done_s && (phase_r == 4'd0);
        sat_set_s   = keep_s && clamp_s;
        pop_s       = valid_r && i_ready;
        full_s      = (cnt_r == FULL_CNT);
        push_s      = stage_v_r && (!full_s || pop_s);
        drop_s      = stage_v_r && full_s && !pop_s;
        if (push_s && !pop_s) begin
            cnt_nxt_s = cnt_r + (AW+1)'(1);
        end else if (pop_s && !push_s) begin
            cnt_nxt_s = cnt_r - (AW+1)'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
        // The head register is the visible o_data, so it is pre-computed for the next edge.
        if (pop_s) begin
            if (cnt_r > (AW+1)'(1)) begin
                head_nxt_s = mem_r[AW'(rd_ptr_r + AW'(1))];
            end else if (push_s) begin
                head_nxt_s = stage_d_r;
            end else begin
                head_nxt_s = head_r;
            end
        end else if ((cnt_r == '0) && push_s) begin
            head_nxt_s = stage_d_r;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Skip counter saturates at SKIP; phase counter only runs on post-skip samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            skip_r  <= 8'd0;
            phase_r <= 4'd0;
        end else if (i_data_valid) begin
            if (!skip_done_s) begin
                skip_r <= skip_r + 8'd1;
            end else if (phase_r == 4'(DECIM-1)) begin
                phase_r <= 4'd0;
            end else begin
                phase_r <= phase_r + 4'd1;
            end
        end
    end

    // Stage register holding the formatted kept sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage_v_r <= 1'b0;
            stage_d_r <= '0;
        end else begin
            stage_v_r <= keep_s;
            if (keep_s) begin
                stage_d_r <= fmt_s;
            end
        end
    end

    // FIFO storage, pointers, occupancy and registered head/valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            cnt_r    <= '0;
            valid_r  <= 1'b0;
            head_r   <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= stage_d_r;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            cnt_r   <= cnt_nxt_s;
            valid_r <= (cnt_nxt_s != '0);
            head_r  <= head_nxt_s;
        end
    end

    // Sticky flags: a setting event beats a coincident clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overrun_r <= 1'b0;
            sat_r     <= 1'b0;
        end else begin
            overrun_r <= drop_s | (overrun_r & ~i_clr);
            sat_r     <= sat_set_s | (sat_r & ~i_clr);
        end
    end

`ifdef FIR_FMT_SAT_CNT_EN
    logic [15:0] sat_cnt_r;

    // Saturated-sample counter, holds at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sat_cnt_r <= 16'd0;
        end else if (i_clr) begin
            sat_cnt_r <= sat_set_s ? 16'd1 : 16'd0;
        end else if (sat_set_s && (sat_cnt_r != 16'hFFFF)) begin
            sat_cnt_r <= sat_cnt_r + 16'd1;
        end
    end

    assign o_sat_cnt = sat_cnt_r;
`endif

    assign o_data    = head_r;
    assign o_valid   = valid_r;
    assign o_overrun = overrun_r;
    assign o_sat     = sat_r;

endmodule

// File: tb/tb_fir_out_formatter.sv
// Bench for fir_out_formatter: three instances (default, DECIM=4, SKIP=2) share one stimulus
// and are compared every cycle against a queue-based model, plus directed literal checks.
module tb_fir_out_formatter;

    logic               clk = 1'b0;
    logic               rst_n, dv, ready, clr;
    logic signed [32:0] din;
    logic [15:0]        od [3];
    logic               ov [3];
    logic               ovr [3];
    logic               sat [3];
`ifdef FIR_FMT_SAT_CNT_EN
    logic [15:0]        scnt [3];
`endif

    int checks   = 0;
    int failures = 0;
    int dec_p [3] = '{1, 4, 1};
    int skp_p [3] = '{0, 0, 2};

    int mq [3][$];
    int olog [3][$];
    int m_skip [3], m_phase [3], m_sval [3], m_scnt [3];
    bit m_sv [3], m_sat [3], m_ovr [3];

    always #5 clk = ~clk;

    fir_out_formatter u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_data_valid(dv), .i_clr(clr),
        .o_data(od[0]), .o_valid(ov[0]), .i_ready(ready), .o_overrun(ovr[0]),
`ifdef FIR_FMT_SAT_CNT_EN
        .o_sat_cnt(scnt[0]),
`endif
        .o_sat(sat[0])
    );

    fir_out_formatter #(.DECIM(4)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_data_valid(dv), .i_clr(clr),
        .o_data(od[1]), .o_valid(ov[1]), .i_ready(ready), .o_overrun(ovr[1]),
`ifdef FIR_FMT_SAT_CNT_EN
        .o_sat_cnt(scnt[1]),
`endif
        .o_sat(sat[1])
    );

    fir_out_formatter #(.SKIP(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_data_valid(dv), .i_clr(clr),
        .o_data(od[2]), .o_valid(ov[2]), .i_ready(ready), .o_overrun(ovr[2]),
`ifdef FIR_FMT_SAT_CNT_EN
        .o_sat_cnt(scnt[2]),
`endif
        .o_sat(sat[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void m_reset(input int d);
        mq[d].delete();
        m_skip[d] = 0; m_phase[d] = 0; m_sval[d] = 0; m_scnt[d] = 0;
        m_sv[d] = 1'b0; m_sat[d] = 1'b0; m_ovr[d] = 1'b0;
    endfunction

    // One clock of the model: the FIFO is a queue of at most 4 entries.
    function automatic void m_step(input int d);
        longint x, r;
        bit keep, clamped, sset, oset, pop;
        int sz;
        sz   = mq[d].size();
        pop  = (sz > 0) && ready;
        oset = 1'b0;
        if (pop) void'(mq[d].pop_front());
        if (m_sv[d]) begin
            if (sz == 4 && !pop) oset = 1'b1;
            else mq[d].push_back(m_sval[d]);
        end
        keep = 1'b0;
        if (dv) begin
            if (m_skip[d] < skp_p[d]) m_skip[d]++;
            else begin
                keep = (m_phase[d] == 0);
                m_phase[d] = (m_phase[d] + 1) % dec_p[d];
            end
        end
        x = din;
        r = (x + 64'sd16384) >>> 15;
        clamped = 1'b0;
        if (r > 32767) begin r = 32767; clamped = 1'b1; end
        else if (r < -32768) begin r = -32768; clamped = 1'b1; end
        sset = keep && clamped;
        m_sv[d]   = keep;
        m_sval[d] = int'(r);
        m_sat[d]  = sset || (m_sat[d] && !clr);
        m_ovr[d]  = oset || (m_ovr[d] && !clr);
        if (clr) m_scnt[d] = sset ? 1 : 0;
        else if (sset && m_scnt[d] < 65535) m_scnt[d]++;
    endfunction

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        for (int d = 0; d < 3; d++) m_reset(d);
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (!rst_n) begin
                    m_reset(d);
                    chk($sformatf("rst_data_u%0d", d), int'(od[d]), 0);
                end
                chk($sformatf("valid_u%0d", d), int'(ov[d]), (mq[d].size() > 0) ? 1 : 0);
                if (mq[d].size() > 0)
                    chk($sformatf("data_u%0d", d), int'($signed(od[d])), mq[d][0]);
                chk($sformatf("sat_u%0d", d), int'(sat[d]), int'(m_sat[d]));
                chk($sformatf("ovr_u%0d", d), int'(ovr[d]), int'(m_ovr[d]));
`ifdef FIR_FMT_SAT_CNT_EN
                chk($sformatf("satcnt_u%0d", d), int'(scnt[d]), m_scnt[d]);
`endif
                if (rst_n && ov[d] && ready) olog[d].push_back(int'($signed(od[d])));
                if (rst_n) m_step(d);
            end
        end
    end

    task automatic send(input longint v);
        din = 33'(v);
        dv  = 1'b1;
        @(posedge clk); #1;
        dv  = 1'b0;
    endtask

    task automatic idle(input int n);
        dv = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 3; d++) olog[d].delete();
    endtask

    task automatic chk_log(input string name, input int d, input int e [5], input int n);
        chk({name, "_count"}, olog[d].size(), n);
        for (int i = 0; i < n && i < olog[d].size(); i++)
            chk($sformatf("%s_%0d", name, i), olog[d][i], e[i]);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; dv = 1'b0; ready = 1'b1; clr = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", int'(ov[0]), 0);
        chk("reset_data", int'(od[0]), 0);
        rst_n = 1'b1;
        idle(1);
        chk("reset_flags", int'(sat[0]) + int'(ovr[0]), 0);

        // Rounding, with the 2-cycle latency pinned on the first sample.
        clear_logs();
        send(32768);
        chk("rnd_lat_t1_valid", int'(ov[0]), 0);
        idle(1);
        chk("rnd_lat_t2_valid", int'(ov[0]), 1);
        chk("rnd_lat_t2_data", int'($signed(od[0])), 1);
        send(16384); send(-16384); send(16383);
        idle(4);
        chk_log("rnd", 0, '{1, 1, 0, 0, 0}, 4);

        // Saturation and flag clear.
        clear_logs();
        send(64'sd2147483648);
        send(-64'sd2147483648);
        chk("sat_flag", int'(sat[0]), 1);
        idle(3);
        chk_log("sat", 0, '{32767, -32768, 0, 0, 0}, 2);
`ifdef FIR_FMT_SAT_CNT_EN
        chk("sat_cnt_two", int'(scnt[0]), 2);
`endif
        pulse_clr();
        chk("clr_sat", int'(sat[0]), 0);
        chk("clr_ovr", int'(ovr[0]), 0);
`ifdef FIR_FMT_SAT_CNT_EN
        chk("clr_sat_cnt", int'(scnt[0]), 0);
`endif

        // Decimation by 4.
        do_reset();
        clear_logs();
        for (int k = 1; k <= 12; k++) send(longint'(k) * 32768);
        idle(4);
        chk_log("decim", 1, '{1, 5, 9, 0, 0}, 3);

        // Skip of 2.
        do_reset();
        clear_logs();
        for (int k = 1; k <= 4; k++) send(longint'(k) * 32768);
        idle(4);
        chk_log("skip", 2, '{3, 4, 0, 0, 0}, 2);

        // Overrun with the consumer stalled.
        do_reset();
        clear_logs();
        ready = 1'b0;
        for (int k = 1; k <= 5; k++) send(longint'(k) * 32768);
        chk("ovr_before", int'(ovr[0]), 0);
        idle(1);
        chk("ovr_after_5th", int'(ovr[0]), 1);
        ready = 1'b1;
        idle(6);
        chk_log("ovr_drain", 0, '{1, 2, 3, 4, 0}, 4);
        chk("ovr_drain_empty", int'(ov[0]), 0);

        // Full FIFO with push and pop on the same edge.
        pulse_clr();
        clear_logs();
        ready = 1'b0;
        for (int k = 1; k <= 5; k++) send(longint'(k) * 32768);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        chk("full_pushpop_ovr", int'(ovr[0]), 0);
        idle(1);
        chk("full_pushpop_ovr_late", int'(ovr[0]), 0);
        ready = 1'b1;
        idle(7);
        chk_log("full_pushpop", 0, '{1, 2, 3, 4, 5}, 5);

        // Mid-stream asynchronous reset with three entries queued.
        do_reset();
        ready = 1'b0;
        send(32768); send(65536); send(98304);
        idle(2);
        chk("pre_rst_valid", int'(ov[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("async_rst_valid_u%0d", d), int'(ov[d]), 0);
            chk($sformatf("async_rst_data_u%0d", d), int'(od[d]), 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready = 1'b1;
        clear_logs();
        send(7 * 32768);
        chk("post_rst_t1_valid", int'(ov[1]), 0);
        idle(1);
        chk("post_rst_t2_valid_decim", int'(ov[1]), 1);
        chk("post_rst_t2_data_decim", int'($signed(od[1])), 7);
        chk("post_rst_t2_data", int'($signed(od[0])), 7);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_out_formatter.md
# fir_out_formatter

Downstream stage of the 50th-order FIR filter. It takes the filter's 33-bit signed accumulator output, rounds and saturates it to a 16-bit sample, optionally decimates, and buffers results in a small first-word-fall-through FIFO. The FIFO drives a valid/ready stream towards the DAC or serialiser, and the block flags any sample lost to back-pressure.

## Interface
Parameters:
- `IN_WIDTH`, 33: width of the filter output sample (signed).
- `OUT_WIDTH`, 16: width of the formatted sample (signed).
- `SHIFT`, 15: right-shift applied after rounding (Q15 taps). Legal range 1..`IN_WIDTH`-`OUT_WIDTH`.
- `DECIM`, 1: keep one of every `DECIM` accepted samples. Legal range 1..16.
- `SKIP`, 0: number of accepted samples discarded after reset (pipeline fill). Legal range 0..255.
- `FIFO_DEPTH`, 4: output FIFO entries. Must be a power of two, ≥2.

Ports:
- `i_clk` input 1: clock. One clock domain.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_data` input `IN_WIDTH`: signed filter output.
- `i_data_valid` input 1: `i_data` holds a new filter result this cycle. One sample per asserted cycle.
- `i_clr` input 1: synchronous clear of the sticky flags and counter.
- `o_data` output `OUT_WIDTH`: signed sample at the FIFO head.
- `o_valid` output 1: `o_data` is valid (FIFO not empty).
- `i_ready` input 1: consumer accepts `o_data` when `o_valid && i_ready`.
- `o_overrun` output 1: sticky flag; a kept sample was dropped because the FIFO was full.
- `o_sat` output 1: sticky flag; at least one sample saturated.

## Operation
- **Accept path.** `i_data_valid` high means the sample is accepted. The skip counter counts accepted samples from 0 until it reaches `SKIP`; samples arriving before that are discarded entirely. They do not advance the decimation phase and do not set flags.
- **Decimation.** Phase counter runs 0..`DECIM`-1 and increments on each post-skip accepted sample, wrapping to 0. A sample is kept only when the phase equals 0. The first post-skip sample is therefore always kept.
- **Rounding.**
  - Sign-extend `i_data` to `IN_WIDTH`+1 bits.
  - Add 2^(`SHIFT`-1) (round half toward +inf).
  - Arithmetic shift right by `SHIFT`.
- **Saturation.**
  - Clamp the result to [-2^(`OUT_WIDTH`-1), 2^(`OUT_WIDTH`-1)-1].
  - Clamping sets `o_sat` (only for kept samples).
- **Stage register.** Kept samples pass through one register stage holding the rounded/saturated value plus a write-valid bit.
- **FIFO.**
  - A write-valid stage pushes into the FIFO at the next edge.
  - If the FIFO is full and there is no pop in the same cycle, the sample is dropped and `o_overrun` is set.
  - A simultaneous push and pop on a full FIFO succeeds; occupancy is unchanged.
  - Pop on empty never occurs, because `o_valid` is low.
- **Output.** `o_data` always reflects the FIFO head. The value is don't-care while `o_valid` is low, but must not be X after reset (registers reset to 0).
- **Flag clear.** `i_clr` clears `o_overrun` and `o_sat` at the next edge. If a setting event coincides with `i_clr`, set wins.
- **Reset values.** Reset (asynchronous, any time including mid-stream) forces:
  - FIFO empty, `o_valid`=0, `o_data`=0;
  - flags 0;
  - skip and phase counters 0;
  - stage register invalid.
  
  No partial sample survives reset.

## Timing
- **Latency.** A kept sample presented in cycle t is registered at the end of t and written to the FIFO at the end of t+1. With an empty FIFO, `o_valid`=1 in cycle t+2. There is no empty-FIFO bypass.
- **Throughput.** One sample per cycle in and out. With `i_ready` held high, the FIFO never fills.
- **Handshake.** The pop happens at the edge where `o_valid && i_ready`. `o_data` and `o_valid` change only on clock edges. `o_valid` never depends combinationally on `i_ready`.
- **Flag timing.**
  - `o_sat` asserts one cycle after the saturating sample is presented.
  - `o_overrun` asserts one cycle after the failed push edge.

## Configuration
- **`FIR_FMT_SAT_CNT_EN` defined:**
  - Adds output port `o_sat_cnt` (16 bits).
  - It counts saturated kept samples, holds at 0xFFFF, and is cleared by `i_clr` and by reset.
  - On coincidence with `i_clr`, the count goes to 1 if the same cycle saturates, else 0.
- **`FIR_FMT_SAT_CNT_EN` undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan
All scenarios use default parameters unless stated.
1. **Rounding.** Inputs 32768, 16384, -16384, 16383, with `i_ready`=1.
   - Required `o_data`: 1, 1, 0, 0.
   - Each appears 2 cycles after its input.
2. **Saturation.** Inputs 2^31 and -2^31.
   - Required `o_data`: 32767 and -32768.
   - `o_sat`=1; with the macro defined, `o_sat_cnt`=2.
   - Then pulse `i_clr`: flags and count return to 0.
3. **Decimation.** `DECIM`=4; feed k·32768 for k=1..12 on consecutive cycles.
   - Required outputs: exactly 1, 5, 9.
4. **Skip.** `SKIP`=2; feed 1·32768 to 4·32768.
   - Required outputs: 3, 4 only.
5. **Overrun.** `i_ready`=0; feed 5 samples (values 1..5).
   - `o_overrun`=1 after the 5th.
   - Then raise `i_ready`: outputs 1, 2, 3, 4, after which `o_valid`=0.
   - Also check a full FIFO with push and pop in the same cycle: no overrun.
6. **Reset mid-stream.** Assert `i_rst_n`=0 with 3 entries queued.
   - `o_valid`=0 and `o_data`=0 immediately, without a clock edge.
   - After release, the next sample appears with normal 2-cycle latency and `DECIM` phase 0.
